// File: rtl/hdb3_tx_sched.sv
// hdb3_tx_sched: two-requester frame scheduler feeding an HDB3 encoder.
// Each frame is SYNC_WORD followed by FRAME_LEN payload bytes, sent MSB first.
// Ports:
//   i_clk, i_rst_n       clock; asynchronous active-low reset
//   i_reqN_valid/_data   requester N byte offer (N = 0, 1)
//   o_reqN_ready         byte taken on this edge if valid
//   o_data               serial NRZ bit to the encoder
//   o_frame_start        pulse with the first sync bit
//   o_grant              one-hot frame owner, 00 when idle
//   o_underrun           pulse with the first bit of a filler byte
//   o_busy               high while a frame is on the wire
module hdb3_tx_sched #(
  parameter logic [7:0] SYNC_WORD = 8'h1B,
  parameter int         FRAME_LEN = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_req0_valid,
  input  logic [7:0] i_req0_data,
  output logic       o_req0_ready,
  input  logic       i_req1_valid,
  input  logic [7:0] i_req1_data,
  output logic       o_req1_ready,
  output logic       o_data,
  output logic       o_frame_start,
  output logic [1:0] o_grant,
  output logic       o_underrun,
  output logic       o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PAYLOAD
  } state_e;

  localparam logic [3:0] LAST_BYTE = 4'(FRAME_LEN - 1);

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] byte_cnt_q, byte_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       data_q, data_d;
  logic       fs_q, fs_d;
  logic [1:0] grant_q, grant_d;
  logic       underrun_q, underrun_d;
  logic       busy_q, busy_d;
  logic       prio_q, prio_d;

  logic       boundary;
  logic       cur_valid;
  logic [7:0] cur_data;
  logic       pick1;

  // A new byte is needed only when the next byte is payload:
  // last sync bit, or last bit of any payload byte but the final one.
  assign boundary = (bit_cnt_q == 3'd7) &&
                    ((state_q == ST_SYNC) ||
                     ((state_q == ST_PAYLOAD) &&
                      (byte_cnt_q != LAST_BYTE)));

  assign o_req0_ready = boundary & grant_q[0];
  assign o_req1_ready = boundary & grant_q[1];

  assign cur_valid = grant_q[0] ? i_req0_valid : i_req1_valid;
  assign cur_data  = grant_q[0] ? i_req0_data  : i_req1_data;

  // prio_q = 1 means requester 1 wins a tie.
  assign pick1 = i_req1_valid & (~i_req0_valid | prio_q);

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    fs_d       = 1'b0;
    grant_d    = grant_q;
    underrun_d = 1'b0;
    busy_d     = busy_q;
    prio_d     = prio_q;
    unique case (state_q)
      ST_IDLE: begin
        data_d = 1'b0;
        if (i_req0_valid | i_req1_valid) begin
          state_d    = ST_SYNC;
          grant_d    = pick1 ? 2'b10 : 2'b01;
          data_d     = SYNC_WORD[7];
          shift_d    = {SYNC_WORD[6:0], 1'b0};
          bit_cnt_d  = 3'd0;
          byte_cnt_d = 4'd0;
          fs_d       = 1'b1;
          busy_d     = 1'b1;
        end
      end
      ST_SYNC, ST_PAYLOAD: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q != 3'd7) begin
          data_d  = shift_q[7];
          shift_d = {shift_q[6:0], 1'b0};
        end else if (boundary) begin
          if (state_q == ST_SYNC) begin
            state_d    = ST_PAYLOAD;
            byte_cnt_d = 4'd0;
          end else begin
            byte_cnt_d = byte_cnt_q + 4'd1;
          end
          if (cur_valid) begin
            data_d  = cur_data[7];
            shift_d = {cur_data[6:0], 1'b0};
          end else begin
            data_d     = 1'b0;
            shift_d    = 8'h00;
            underrun_d = 1'b1;
          end
        end else begin
          // Final payload bit done: release and hand priority over.
          state_d    = ST_IDLE;
          data_d     = 1'b0;
          shift_d    = 8'h00;
          byte_cnt_d = 4'd0;
          grant_d    = 2'b00;
          busy_d     = 1'b0;
          prio_d     = grant_q[0];
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 3'd0;
      byte_cnt_q <= 4'd0;
      shift_q    <= 8'h00;
      data_q     <= 1'b0;
      fs_q       <= 1'b0;
      grant_q    <= 2'b00;
      underrun_q <= 1'b0;
      busy_q     <= 1'b0;
      prio_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      fs_q       <= fs_d;
      grant_q    <= grant_d;
      underrun_q <= underrun_d;
      busy_q     <= busy_d;
      prio_q     <= prio_d;
    end
  end

  assign o_data        = data_q;
  assign o_frame_start = fs_q;
  assign o_grant       = grant_q;
  assign o_underrun    = underrun_q;
  assign o_busy        = busy_q;

endmodule

// File: tb/tb_hdb3_tx_sched.sv
// tb_hdb3_tx_sched: directed bench for hdb3_tx_sched.
// SYNC_WORD=8'h1B, FRAME_LEN=4; expected streams are hand-built.
module tb_hdb3_tx_sched;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_req0_valid;
  logic [7:0] i_req0_data;
  logic       o_req0_ready;
  logic       i_req1_valid;
  logic [7:0] i_req1_data;
  logic       o_req1_ready;
  logic       o_data;
  logic       o_frame_start;
  logic [1:0] o_grant;
  logic       o_underrun;
  logic       o_busy;

  hdb3_tx_sched #(
    .SYNC_WORD(8'h1B),
    .FRAME_LEN(4)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_req0_valid (i_req0_valid),
    .i_req0_data  (i_req0_data),
    .o_req0_ready (o_req0_ready),
    .i_req1_valid (i_req1_valid),
    .i_req1_data  (i_req1_data),
    .o_req1_ready (o_req1_ready),
    .o_data       (o_data),
    .o_frame_start(o_frame_start),
    .o_grant      (o_grant),
    .o_underrun   (o_underrun),
    .o_busy       (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_chk;
  int n_pass;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  bit hold1;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic drive();
    i_req0_valid = (q0.size() > 0);
    i_req0_data  = i_req0_valid ? q0[0] : 8'h00;
    i_req1_valid = (q1.size() > 0) && !hold1;
    i_req1_data  = i_req1_valid ? q1[0] : 8'h00;
  endtask

  // One clock; handshakes are judged at the falling edge.
  task automatic step();
    bit t0, t1;
    @(negedge i_clk);
    t0 = o_req0_ready && i_req0_valid;
    t1 = o_req1_ready && i_req1_valid;
    @(posedge i_clk);
    #1;
    if (t0) void'(q0.pop_front());
    if (t1) void'(q1.pop_front());
    drive();
  endtask

  task automatic wait_frame(input string tag);
    bit seen;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (o_frame_start) begin
        seen = 1;
        break;
      end
      step();
    end
    chk({tag, "_start"}, 64'(seen), 64'd1);
  endtask

  // Called on the cycle showing the first sync bit; returns on the
  // idle cycle that follows the frame.
  task automatic expect_frame(input string tag, input logic [1:0] g,
                              input logic [39:0] bits,
                              input logic [39:0] umask);
    logic [39:0] got_b, got_u;
    int gbad, bbad, fsc, rdyc, xbad;
    gbad = 0; bbad = 0; fsc = 0; rdyc = 0; xbad = 0;
    for (int i = 0; i < 40; i++) begin
      got_b[39-i] = o_data;
      got_u[39-i] = o_underrun;
      if (o_grant !== g) gbad++;
      if (o_busy !== 1'b1) bbad++;
      if (o_frame_start) fsc++;
      if (g[0] ? o_req0_ready : o_req1_ready) rdyc++;
      if (g[0] ? o_req1_ready : o_req0_ready) xbad++;
      step();
    end
    chk({tag, "_bits"}, 64'(got_b), 64'(bits));
    chk({tag, "_undr"}, 64'(got_u), 64'(umask));
    chk({tag, "_gbad"}, 64'(gbad), 64'd0);
    chk({tag, "_busy"}, 64'(bbad), 64'd0);
    chk({tag, "_fsc"}, 64'(fsc), 64'd1);
    chk({tag, "_rdy"}, 64'(rdyc), 64'd4);
    chk({tag, "_xrdy"}, 64'(xbad), 64'd0);
    chk({tag, "_idle"}, {61'd0, o_grant, o_busy}, 64'd0);
    chk({tag, "_idat"}, 64'(o_data), 64'd0);
  endtask

  task automatic do_reset();
    q0.delete();
    q1.delete();
    hold1 = 0;
    drive();
    i_rst_n = 1'b0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    int bad;
    n_chk = 0;
    n_pass = 0;
    hold1 = 0;
    i_rst_n = 1'b0;
    drive();
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_out", {57'd0, o_data, o_frame_start, o_grant,
                    o_underrun, o_busy, o_req0_ready}, 64'd0);
    chk("rst_rdy1", 64'(o_req1_ready), 64'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    // req0 alone, bytes 11 22 33 44
    q0 = '{8'h11, 8'h22, 8'h33, 8'h44};
    drive();
    wait_frame("t1");
    expect_frame("t1", 2'b01, 40'h1B11223344, 40'h0);
    chk("t1_q0", 64'(q0.size()), 64'd0);

    // long idle stretch
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (o_data || o_busy || o_req0_ready || o_req1_ready ||
          (o_grant != 2'b00)) bad++;
      step();
    end
    chk("t2_idle", 64'(bad), 64'd0);

    // req0 owned last, so req1 holds priority; reset mid-frame
    q0 = '{8'h31, 8'h32, 8'h33, 8'h34};
    q1 = '{8'hA5, 8'hFF, 8'h5A, 8'h3C};
    drive();
    wait_frame("t6");
    chk("t6_g1", 64'(o_grant), 64'd2);
    repeat (19) step();
    chk("t6_pre", {62'd0, o_grant[1], o_data}, 64'd3);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("t6_async", {58'd0, o_data, o_frame_start, o_grant,
                     o_underrun, o_busy}, 64'd0);
    chk("t6_ardy", {62'd0, o_req0_ready, o_req1_ready}, 64'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    wait_frame("t6b");
    expect_frame("t6b", 2'b01, 40'h1B31323334, 40'h0);
    q1.delete();
    drive();

    // round robin with both valid throughout
    do_reset();
    q0 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    q1 = '{8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86, 8'h87, 8'h88};
    drive();
    wait_frame("t3");
    expect_frame("t3a", 2'b01, 40'h1B01020304, 40'h0);
    step();
    chk("t3b_fs", 64'(o_frame_start), 64'd1);
    expect_frame("t3b", 2'b10, 40'h1B81828384, 40'h0);
    step();
    chk("t3c_fs", 64'(o_frame_start), 64'd1);
    expect_frame("t3c", 2'b01, 40'h1B05060708, 40'h0);
    step();
    chk("t3d_fs", 64'(o_frame_start), 64'd1);
    expect_frame("t3d", 2'b10, 40'h1B85868788, 40'h0);
    chk("t3_q", 64'(q0.size() + q1.size()), 64'd0);

    // req1 drops valid for payload byte 3
    q1 = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    drive();
    wait_frame("t4");
    fork
      expect_frame("t4", 2'b10, 40'h1BC1C200C3, 40'h0000008000);
      begin
        repeat (16) @(posedge i_clk);
        #2;
        hold1 = 1;
        drive();
        repeat (8) @(posedge i_clk);
        #2;
        hold1 = 0;
        drive();
      end
    join
    chk("t4_q1", 64'(q1.size()), 64'd1);
    q1.delete();
    drive();

    // req1 turns up mid-frame and must wait its turn
    q0 = '{8'hD1, 8'hD2, 8'hD3, 8'hD4};
    drive();
    wait_frame("t5");
    fork
      expect_frame("t5a", 2'b01, 40'h1BD1D2D3D4, 40'h0);
      begin
        repeat (10) @(posedge i_clk);
        #2;
        q1 = '{8'hE1, 8'hE2, 8'hE3, 8'hE4};
        drive();
      end
    join
    step();
    chk("t5b_fs", 64'(o_frame_start), 64'd1);
    expect_frame("t5b", 2'b10, 40'h1BE1E2E3E4, 40'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/hdb3_tx_sched.md
HDB3_TX_SCHED -- requirements
Module: hdb3_tx_sched

Interface
REQ-001 The module SHALL have parameter SYNC_WORD, default 8'h1B, the frame sync byte sent MSB first.
REQ-002 The module SHALL have parameter FRAME_LEN, default 4, the payload bytes per frame (legal range 1..15).
REQ-003 i_clk  input  1  single clock; one serial bit leaves per cycle.
REQ-004 i_rst_n  input  1  asynchronous active-low reset.
REQ-005 i_req0_valid  input  1  requester 0 has a byte on i_req0_data.
REQ-006 i_req0_data  input  8  requester 0 payload byte.
REQ-007 o_req0_ready  output  1  requester 0 byte is taken on this edge if valid.
REQ-008 i_req1_valid, i_req1_data[7:0], o_req1_ready SHALL be identical in width and meaning for requester 1.
REQ-009 o_data  output  1  serial NRZ bit stream feeding the HDB3 encoder i_data input.
REQ-010 o_frame_start  output  1  one-cycle pulse coincident with the first sync bit on o_data.
REQ-011 o_grant  output  2  one-hot owner of the current frame; 2'b00 when idle.
REQ-012 o_underrun  output  1  one-cycle pulse when a filler byte is substituted.
REQ-013 o_busy  output  1  high during the SYNC and PAYLOAD states.

Function
REQ-014 The FSM SHALL have the states IDLE, SYNC and PAYLOAD; o_data, o_frame_start, o_grant, o_underrun and o_busy SHALL be registered outputs.
REQ-015 In IDLE, o_data SHALL be 0 every cycle, so the encoder sees zeros and applies its substitutions.
REQ-016 In IDLE, at an edge where either valid is high, the block SHALL grant one requester and enter SYNC.
- Both valid: the requester holding priority wins.
- One valid: that requester wins regardless of priority.
REQ-017 The grant SHALL stay locked for the whole frame; the other requester's ready SHALL stay 0 until it owns a frame.
REQ-018 SYNC SHALL shift SYNC_WORD MSB first over 8 cycles; o_frame_start SHALL be high in the first of these cycles.
REQ-019 Byte boundary: o_readyN SHALL be asserted combinationally for the granted requester only when the bit counter is 7 and the next byte is payload.
- This covers the last SYNC bit and the last bit of every payload byte except the final one.
REQ-020 On a boundary edge with valid high, the byte SHALL be loaded into the shift register and sent MSB first over the next 8 cycles.
REQ-021 On a boundary edge with valid low, the block SHALL send filler 8'h00 instead.
- The filler counts toward FRAME_LEN.
- o_underrun SHALL pulse for one cycle with the filler's first bit.
REQ-022 A frame SHALL last exactly 8*(1+FRAME_LEN) cycles; there is no early termination.
REQ-023 After the last payload bit, the block SHALL return to IDLE for at least 1 cycle (o_data=0, o_grant=0), then rearbitrate.
REQ-024 At frame end, priority SHALL move to the requester that did not own the frame (round robin).
REQ-025 Valid held high by a requester that is not granted SHALL NOT be consumed or dropped; the data must stay stable until ready.
REQ-026 The bit counter SHALL be 3 bits and wrap 7->0; the byte counter SHALL be 4 bits, compared against FRAME_LEN-1.

Reset
REQ-027 On i_rst_n low, the block SHALL enter the following state immediately, without waiting for a clock edge:
- state IDLE;
- o_data=0, o_frame_start=0, o_grant=2'b00, o_underrun=0, o_busy=0;
- both ready outputs 0, counters 0, shift register 0;
- priority to requester 0.
REQ-028 Reset in mid-frame SHALL abandon the frame with no partial byte retained; the first frame after release SHALL start from the sync byte.
REQ-029 The block SHALL be reset from the same i_rst_n as the HDB3 encoder.

Verification (SYNC_WORD=8'h1B, FRAME_LEN=4)
REQ-030 req0 only, bytes 11,22,33,44.
- o_data = 00011011 00010001 00100010 00110011 01000100.
- Four ready pulses; o_grant=01 for 40 cycles.
- o_frame_start once; then o_data=0.
REQ-031 Both valid continuously -> o_grant sequence 01,10,01,10 across frames, with 1 idle cycle (o_grant=00) between frames.
REQ-032 req1 owns the frame and drops valid before payload byte 3.
- Byte 3 is sent as 00000000 with one o_underrun pulse.
- Byte 4 is taken normally; the frame is still 40 cycles.
REQ-033 No valid for 100 cycles -> o_data=0, o_busy=0, ready outputs 0 throughout.
REQ-034 Reset asserted on bit 3 of payload byte 2.
- All outputs go to reset values immediately.
- After release with both valid, the frame goes to req0 and starts with 00011011.
REQ-035 req1 valid rises during req0's frame -> o_req1_ready stays 0 until req1's own frame; its held byte is sent first in that frame.
